inst_fetch_queue: RTL and testbench

Requester-side front end for the synchronous instruction memory (SynInstMem).
- Generates sequential fetch addresses and drives them to the memory.
- Tracks the fixed one-cycle read latency and captures returned words with their PCs into a small FIFO.
- Presents the FIFO head to the decode stage over a valid/ready handshake.
- Supports pipeline redirects (branch/jump) with full flush of queued and in-flight fetches.

---
 rtl/inst_fetch_queue.sv | 105 ++++++++++
 tb/tb_inst_fetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetch front end for a one-cycle-latency instruction memory.
// Latency: address in cycle N -> pushed at end of N+1 -> visible on out_* in N+2.
// Backpressure: issue stalls while queued plus in-flight words would exceed DEPTH.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          req_valid_q, req_valid_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;

  // Head presentation: zeros whenever the queue is empty.
  always_comb begin
    out_valid = (count_q != '0);
    out_pc    = out_valid ? pc_mem[rd_ptr_q]   : 32'h0;
    out_inst  = out_valid ? inst_mem[rd_ptr_q] : 32'h0;
    imem_addr = fetch_pc_q;
  end

  // Next-state: issue guard reserves a slot for every in-flight word, since the memory cannot stall.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    // A pop in this cycle is deliberately not credited to the issue decision.
    issue       = !redirect && ((count_q + CW'(req_valid_q)) < DEPTH_C);
    push        = req_valid_q && !redirect;
    pop         = out_valid && out_ready;

    if (redirect) begin
      // The handshake this cycle still completes; everything behind it is dropped.
      fetch_pc_d  = redirect_pc & 32'hFFFF_FFFC;
      req_valid_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end else begin
      req_valid_d = issue;
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Queue storage: capture the returning word together with the PC that requested it.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr_q]   <= req_pc_q;
      inst_mem[wr_ptr_q] <= imem_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_inst  (imem_inst),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_ready  (out_ready)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) imem_inst <= memf(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of words the consumer should see, plus one in-flight request.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  logic        m_init  = 1'b0;
  logic        m_infl  = 1'b0;
  logic [31:0] m_req   = '0;
  logic [31:0] m_fetch = '0;
  logic        seq_ok  = 1'b0;
  logic [31:0] last_pc = '0;
  int          sz0;
  logic        hs;
  logic        iss;

  // Monitor: compare DUT outputs against the model, then advance the model by one edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_inst", out_inst, exp_q[0].inst);
      end else begin
        chk("out_pc_empty", out_pc, 32'h0);
        chk("out_inst_empty", out_inst, 32'h0);
      end
      chk("imem_addr", imem_addr, m_fetch);
      if (out_valid && out_ready && seq_ok)
        chk("pc_sequence", out_pc, last_pc + 32'd4);
    end

    if (rst) begin
      exp_q.delete();
      m_infl  = 1'b0;
      m_fetch = RPC;
      seq_ok  = 1'b0;
      m_init  = 1'b1;
    end else if (m_init) begin
      sz0 = exp_q.size();
      hs  = (sz0 != 0) && out_ready;
      if (hs) begin
        last_pc = exp_q[0].pc;
        seq_ok  = 1'b1;
        void'(exp_q.pop_front());
      end
      if (redirect) begin
        exp_q.delete();
        m_infl  = 1'b0;
        m_fetch = redirect_pc & 32'hFFFF_FFFC;
        seq_ok  = 1'b0;
      end else begin
        if (m_infl) exp_q.push_back('{pc: m_req, inst: memf(m_req)});
        iss    = (sz0 + int'(m_infl)) < DEPTH;
        m_infl = iss;
        if (iss) begin
          m_req   = m_fetch;
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(20);

    // Stalled consumer: exactly DEPTH words queued, fetch address parked.
    rst = 1'b1; cyc(1); rst = 1'b0; out_ready = 1'b0;
    cyc(10);
    chk("stall_addr", imem_addr, RPC + 32'd16);
    out_ready = 1'b1;
    cyc(10);

    // Redirect with queued and in-flight words.
    rst = 1'b1; cyc(1); rst = 1'b0; out_ready = 1'b0;
    cyc(4);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cyc(1);
    redirect = 1'b0;
    chk("redirect_flush_valid", {31'b0, out_valid}, 32'h0);
    chk("redirect_addr", imem_addr, 32'h0000_0100);
    out_ready = 1'b1;
    cyc(10);

    // Redirect coinciding with a head handshake.
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cyc(1);
    redirect = 1'b0;
    cyc(8);

    // Back-to-back redirects: last one wins.
    redirect = 1'b1; redirect_pc = 32'h0000_0300; cyc(1);
    redirect_pc = 32'h0000_0402; cyc(1);
    redirect = 1'b0;
    cyc(8);

    // Reset mid-operation with words queued and one in flight.
    out_ready = 1'b0; cyc(3);
    rst = 1'b1; cyc(1);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_addr", imem_addr, RPC);
    rst = 1'b0; out_ready = 1'b1;
    cyc(6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      out_ready   = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      rst         = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
